shuf_checker: RTL
=================

SHUF_CHECKER -- requirements
Module: shuf_checker

Interface
REQ-001 SHALL have parameter SEED, default 64'h5aef0c8d_d70a4497: LFSR load value.
REQ-002 SHALL have parameter NUM_CYCLES, default 100: checked cycles per run, legal range 1..2^32-1.
REQ-003 SHALL have parameter LAT, default 0: expected latency of the upstream stage, legal values 0 or 1.
REQ-004 clk  input  1: single clock, all state on posedge.
REQ-005 rst  input  1: reset, synchronous, active-high.
REQ-006 start  input  1: begin a run; level sampled on posedge.
REQ-007 crc  output  64: stimulus word driven to the stage under check.
REQ-008 cyc  output  32: index of the current run cycle.
REQ-009 in_valid  input  1: in_data is to be checked this cycle.
REQ-010 in_rev  input  1: 1 = in_data is expected bit-reversed; 0 = in natural order.
REQ-011 in_data  input  64: stage output under check.
REQ-012 err_count  output  16: mismatch count, saturating.
REQ-013 first_err_valid  output  1: first_err_cyc holds a captured value.
REQ-014 first_err_cyc  output  32: cyc value at the first mismatch.
REQ-015 done  output  1: run complete.
REQ-016 pass  output  1: done and err_count == 0.

Function
REQ-017 SHALL implement a 3-state FSM:
- IDLE -> RUN on start.
- RUN -> DONE on the cycle cyc == NUM_CYCLES-1; the check on that cycle is still performed.
- DONE -> RUN on start (restart).
- start in RUN is ignored.
REQ-018 On entry to RUN (from IDLE or DONE) SHALL, in the same edge:
- set crc = SEED and cyc = 0;
- clear prev_crc, err_count and first_err_valid.
REQ-019 In RUN, each cycle SHALL:
- update crc <= {crc[62:0], crc[63]^crc[2]^crc[0]};
- set prev_crc <= crc;
- set cyc <= cyc+1.
REQ-020 In IDLE and DONE, crc, prev_crc and cyc SHALL hold.
REQ-021 Expected word SHALL be:
- base = (LAT==0) ? crc : prev_crc;
- exp = in_rev ? base bit-reversed (exp[i] = base[63-i]) : base.
REQ-022 A check SHALL occur when state == RUN, in_valid == 1 and cyc >= LAT; in_valid outside RUN SHALL be ignored.
REQ-023 Mismatch SHALL use 4-state case inequality; any X/Z bit in in_data counts as a mismatch.
REQ-024 On mismatch, err_count SHALL increment by 1, saturating at 16'hFFFF.
REQ-025 On the first mismatch of a run, SHALL set first_err_cyc = cyc and first_err_valid = 1; later mismatches SHALL not overwrite either.
REQ-026 done SHALL be 1 exactly while state == DONE.
REQ-027 pass SHALL be the combinational result done && (err_count == 0).
REQ-028 Check and update SHALL add no latency: err_count reflects a mismatch on the edge after the sampled cycle.

Reset
REQ-029 On rst == 1, SHALL go to IDLE and set:
- crc = SEED;
- prev_crc = 0, cyc = 0, err_count = 0;
- first_err_valid = 0, first_err_cyc = 0;
- done = 0, pass = 0.
REQ-030 rst SHALL take priority over start and over an in-progress run; a reset mid-RUN discards all results.

Verification
REQ-031 Reset, then start, LAT=0 -> cycle after start: crc = 64'h5aef0c8d_d70a4497, cyc = 0; next edge: crc = 64'hb5de191b_ae14892e.
REQ-032 LAT=0, NUM_CYCLES=100, in_data driven = in_rev ? reversed(crc) : crc with in_rev toggling each cycle -> done after 100 RUN cycles, err_count = 0, pass = 1.
REQ-033 LAT=1, in_data = registered stage output -> no error counted at cyc = 0; 0 errors total; pass = 1.
REQ-034 Single-bit flip injected at cyc = 7 and cyc = 20 -> err_count = 2, first_err_cyc = 7, first_err_valid = 1, pass = 0.
REQ-035 X on in_data[5] at cyc = 3 -> err_count = 1, first_err_cyc = 3.
REQ-036 rst asserted at cyc = 50 -> IDLE, all outputs at reset values; then start in DONE -> counters cleared and crc = SEED on the next cycle.

Source files
------------

// File: rtl/shuf_checker.sv
// Self-checking stimulus source: drives an LFSR word to a shuffle stage and checks
// that the stage returns it, in natural or bit-reversed order, after LAT cycles.
module shuf_checker #(
   parameter logic [63:0] SEED       = 64'h5aef0c8d_d70a4497,
   parameter logic [31:0] NUM_CYCLES = 32'd100,
   parameter int          LAT        = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [63:0] crc,
   output logic [31:0] cyc,
   input  logic        in_valid,
   input  logic        in_rev,
   input  logic [63:0] in_data,
   output logic [15:0] err_count,
   output logic        first_err_valid,
   output logic [31:0] first_err_cyc,
   output logic        done,
   output logic        pass
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [31:0] LAST_CYC = NUM_CYCLES - 32'd1;

   state_t      state_reg, state_next;
   logic [63:0] crc_reg, prev_crc_reg;
   logic [31:0] cyc_reg;
   logic [15:0] err_count_reg;
   logic        first_err_valid_reg;
   logic [31:0] first_err_cyc_reg;

   logic        load;
   logic        chk_en;
   logic        mismatch;
   logic [63:0] base_word, rev_word, exp_word;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (cyc_reg == LAST_CYC) state_next = DONE;
         DONE:    if (start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   // A run (re)starts from IDLE or DONE; start seen during RUN is ignored.
   assign load = start && (state_reg != RUN);

   assign base_word = (LAT == 0) ? crc_reg : prev_crc_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 64; gi++) begin : g_rev
         assign rev_word[gi] = base_word[63-gi];
      end
   endgenerate

   assign exp_word = in_rev ? rev_word : base_word;
   // With LAT=1 the cycle-0 word has no predecessor, so it is not checked.
   assign chk_en   = (LAT == 0) || (cyc_reg != 32'd0);
   assign mismatch = (state_reg == RUN) && in_valid && chk_en && (in_data !== exp_word);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg           <= IDLE;
         crc_reg             <= SEED;
         prev_crc_reg        <= '0;
         cyc_reg             <= '0;
         err_count_reg       <= '0;
         first_err_valid_reg <= 1'b0;
         first_err_cyc_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (load) begin
            crc_reg             <= SEED;
            prev_crc_reg        <= '0;
            cyc_reg             <= '0;
            err_count_reg       <= '0;
            first_err_valid_reg <= 1'b0;
         end else if (state_reg == RUN) begin
            crc_reg      <= {crc_reg[62:0], crc_reg[63] ^ crc_reg[2] ^ crc_reg[0]};
            prev_crc_reg <= crc_reg;
            cyc_reg      <= cyc_reg + 32'd1;
            if (mismatch) begin
               if (err_count_reg != 16'hFFFF)
                  err_count_reg <= err_count_reg + 16'd1;
               if (!first_err_valid_reg) begin
                  first_err_valid_reg <= 1'b1;
                  first_err_cyc_reg   <= cyc_reg;
               end
            end
         end
      end
   end

   assign crc             = crc_reg;
   assign cyc             = cyc_reg;
   assign err_count       = err_count_reg;
   assign first_err_valid = first_err_valid_reg;
   assign first_err_cyc   = first_err_cyc_reg;
   assign done            = (state_reg == DONE);
   assign pass            = done && (err_count_reg == 16'd0);

endmodule
